ppu_quire_acc: RTL and testbench

Pipelined quire (exact fixed-point) multiply-accumulate unit for the PPU, extending the single-shot FMADD path to dot products of arbitrary length. It consumes pairs of decoded operands (`fir_t` plus special tag) as a valid/ready stream and multiplies each pair exactly. Each product is added into a wide two's-complement quire with no intermediate rounding. On the beat marked last, it normalises the quire into one `ops_out_meta_t` for the existing rounding/encoding stage.

---
 rtl/ppu_pkg.sv | 39 +++
 rtl/quire_normalize.sv | 57 +++++
 rtl/ppu_quire_acc.sv | 183 ++++++++++++++++++
 tb/tb_ppu_quire_acc.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU types: decoded operands, rounding-stage metadata, and the quire
// accumulator's pipeline register and state encoding.
package ppu_pkg;

   localparam int N              = 16;
   localparam int ES             = 1;
   localparam int MS             = N - 2;
   localparam int TE_BITS        = $clog2(N) + ES + 2;
   localparam int FRAC_FULL_SIZE = 3 * N - 8;
   localparam int QW             = 16 * N;
   localparam int QF             = QW / 2;

   typedef logic signed [QW-1:0] quire_t;

   typedef struct packed {
      logic                      sign;
      logic signed [TE_BITS-1:0] te;
      logic [MS-1:0]             mant;
   } fir_t;

   typedef struct packed {
      logic                      sign;
      logic signed [TE_BITS-1:0] te;
      logic [FRAC_FULL_SIZE-1:0] frac;
      logic                      frac_truncated;
   } ops_out_meta_t;

   typedef struct packed {
      logic [2*MS-1:0]         prod;
      logic                    sign;
      logic signed [TE_BITS:0] te;
      logic                    last;
      logic                    zero;
      logic                    nar;
   } quire_s1_t;

   typedef enum logic [1:0] {ACC, DRAIN, NORM, OUT} quire_state_e;

endpackage

// File: rtl/quire_normalize.sv
// Combinational quire normaliser: magnitude, leading-one detect, alignment of
// the bits below the leading one, and exponent clamping to the TE_BITS range.
module quire_normalize #(
   parameter int QW = ppu_pkg::QW,
   parameter int QF = ppu_pkg::QF
) (
   input  logic signed [QW-1:0]   quire,
   input  logic                   sticky,
   output ppu_pkg::ops_out_meta_t meta,
   output logic                   zero
);
   import ppu_pkg::*;

   localparam int PW = $clog2(QW);
   localparam logic signed [PW+1:0] TE_HI = (PW+2)'(2 ** (TE_BITS - 1) - 1);
   localparam logic signed [PW+1:0] TE_LO = -TE_HI - 1;

   logic [QW-1:0]          mag;
   logic [QW-1:0]          aligned;
   logic [PW-1:0]          lead;
   logic signed [PW+1:0]   te_wide;

   always_comb begin
      mag = quire[QW-1] ? QW'(-quire) : QW'(quire);
      lead = '0;
      for (int i = 0; i < QW; i++) begin
         if (mag[i]) lead = PW'(i);
      end
      // Leading one lands on the MSB; frac is the field directly under it.
      aligned = mag << (PW'(QW - 1) - lead);
      te_wide = $signed({2'b00, lead}) - $signed((PW+2)'(QF));

      meta = '0;
      zero = 1'b0;
      if (mag == '0) begin
         zero = !sticky;
         if (sticky) begin
            meta.te             = TE_BITS'(TE_LO);
            meta.frac_truncated = 1'b1;
         end
      end else begin
         meta.sign           = quire[QW-1];
         meta.frac           = aligned[QW-2 -: FRAC_FULL_SIZE];
         meta.frac_truncated = (|aligned[QW-2-FRAC_FULL_SIZE:0]) | sticky;
         if (te_wide > TE_HI) begin
            meta.te             = TE_BITS'(TE_HI);
            meta.frac_truncated = 1'b1;
         end else if (te_wide < TE_LO) begin
            meta.te             = TE_BITS'(TE_LO);
            meta.frac_truncated = 1'b1;
         end else begin
            meta.te = TE_BITS'(te_wide);
         end
      end
   end

endmodule

// File: rtl/ppu_quire_acc.sv
// Pipelined exact quire multiply-accumulate for posit dot products.
// Optional saturation/overflow reporting is enabled by defining PPU_QUIRE_OVF_EN.
module ppu_quire_acc #(
   parameter int N  = ppu_pkg::N,
   parameter int ES = ppu_pkg::ES,
   parameter int QW = 16 * N,
   parameter int QF = QW / 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  ppu_pkg::fir_t          in_a_i,
   input  ppu_pkg::fir_t          in_b_i,
   input  logic                   in_a_special_i,
   input  logic                   in_b_special_i,
   input  logic                   in_last_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output ppu_pkg::ops_out_meta_t out_meta_o,
   output logic                   out_nar_o,
   output logic                   out_zero_o
`ifdef PPU_QUIRE_OVF_EN
   ,
   output logic                   ovf_o
`endif
);
   import ppu_pkg::*;

   // Wide enough for any te sum plus the QF offset, with sign.
   localparam int SH_W = $clog2(QW) + $clog2(N) + ES + 2;

   quire_state_e          state_reg, state_next;
   quire_s1_t             s1;
   logic                  s1_valid;
   logic                  in_fire;
   logic signed [QW-1:0]  quire_reg;
   logic                  sticky_reg, nar_reg;
   logic [SH_W-1:0]       sh, rsh;
   logic [QW-1:0]         mag, addend, sum;
   logic                  drop;
   ops_out_meta_t         norm_meta, out_meta_reg;
   logic                  norm_zero, out_nar_reg, out_zero_reg;

   assign in_fire = in_valid_i && (state_reg == ACC);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else begin
         s1_valid <= in_fire;
         if (in_fire) begin
            s1.prod <= (2*MS)'(in_a_i.mant) * (2*MS)'(in_b_i.mant);
            s1.sign <= in_a_i.sign ^ in_b_i.sign;
            s1.te   <= (TE_BITS+1)'($signed(in_a_i.te)) + (TE_BITS+1)'($signed(in_b_i.te));
            s1.last <= in_last_i;
            s1.nar  <= (in_a_special_i & in_a_i.sign) | (in_b_special_i & in_b_i.sign);
            s1.zero <= in_a_special_i | in_b_special_i;
         end
      end
   end

   always_comb begin
      sh   = SH_W'($signed(s1.te)) + SH_W'(QF - (2 * MS - 2));
      rsh  = -sh;
      drop = 1'b0;
      if (!sh[SH_W-1]) begin
         mag = QW'(s1.prod) << sh;
      end else begin
         mag  = QW'(s1.prod >> rsh);
         drop = |(s1.prod & ~({(2*MS){1'b1}} << rsh));
      end
      addend = s1.sign ? -mag : mag;
      sum    = quire_reg + addend;
   end

`ifdef PPU_QUIRE_OVF_EN
   localparam logic [QW-1:0] Q_MAX = {1'b0, {(QW-1){1'b1}}};
   localparam logic [QW-1:0] Q_MIN = {1'b1, {(QW-1){1'b0}}};
   logic                 ovf_reg, ovf_out_reg, lost, add_ovf;
   logic [QW+2*MS-1:0]   wide;

   always_comb begin
      wide    = (QW+2*MS)'(s1.prod) << sh;
      lost    = !sh[SH_W-1] && (wide[QW+2*MS-1:QW-1] != '0);
      add_ovf = (quire_reg[QW-1] == addend[QW-1]) && (sum[QW-1] != quire_reg[QW-1]);
   end
   assign ovf_o = ovf_out_reg;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         quire_reg  <= '0;
         sticky_reg <= 1'b0;
         nar_reg    <= 1'b0;
`ifdef PPU_QUIRE_OVF_EN
         ovf_reg    <= 1'b0;
`endif
      end else if (out_valid_o && out_ready_i) begin
         quire_reg  <= '0;
         sticky_reg <= 1'b0;
         nar_reg    <= 1'b0;
`ifdef PPU_QUIRE_OVF_EN
         ovf_reg    <= 1'b0;
`endif
      end else if (s1_valid && s1.nar) begin
         nar_reg <= 1'b1;
      end else if (s1_valid && !s1.zero) begin
`ifdef PPU_QUIRE_OVF_EN
         // Once saturated the quire is frozen until the result is taken.
         if (lost || add_ovf || ovf_reg) begin
            ovf_reg <= 1'b1;
            if (!ovf_reg) quire_reg <= s1.sign ? Q_MIN : Q_MAX;
         end else begin
            quire_reg  <= sum;
            sticky_reg <= sticky_reg | drop;
         end
`else
         quire_reg  <= sum;
         sticky_reg <= sticky_reg | drop;
`endif
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_reg <= ACC;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      case (state_reg)
         ACC: begin
            in_ready_o = 1'b1;
            if (in_valid_i && in_last_i) state_next = DRAIN;
         end
         DRAIN:   if (s1_valid && s1.last) state_next = NORM;
         NORM:    state_next = OUT;
         OUT: begin
            out_valid_o = 1'b1;
            if (out_ready_i) state_next = ACC;
         end
         default: state_next = ACC;
      endcase
   end

   quire_normalize #(.QW(QW), .QF(QF)) u_norm (
      .quire  (quire_reg),
      .sticky (sticky_reg),
      .meta   (norm_meta),
      .zero   (norm_zero)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_meta_reg <= '0;
         out_nar_reg  <= 1'b0;
         out_zero_reg <= 1'b0;
`ifdef PPU_QUIRE_OVF_EN
         ovf_out_reg  <= 1'b0;
`endif
      end else if (state_reg == NORM) begin
         out_nar_reg  <= nar_reg;
         out_zero_reg <= !nar_reg && norm_zero;
         out_meta_reg <= nar_reg ? '0 : norm_meta;
`ifdef PPU_QUIRE_OVF_EN
         ovf_out_reg <= ovf_reg && !nar_reg;
         if (ovf_reg && !nar_reg) begin
            out_meta_reg.te             <= {1'b0, {(TE_BITS-1){1'b1}}};
            out_meta_reg.frac_truncated <= 1'b1;
         end
`endif
      end
   end

   assign out_meta_o = out_meta_reg;
   assign out_nar_o  = out_nar_reg;
   assign out_zero_o = out_zero_reg;

endmodule

// File: tb/tb_ppu_quire_acc.sv
// Directed bench for ppu_quire_acc (N=16, ES=1): latency, dot-product sums,
// cancellation, NaR, exponent clamping, output hold and mid-operation reset.
module tb_ppu_quire_acc;
   import ppu_pkg::*;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          in_valid_i, in_ready_o, in_last_i;
   logic          in_a_special_i, in_b_special_i;
   fir_t          in_a_i, in_b_i;
   logic          out_valid_o, out_ready_i, out_nar_o, out_zero_o;
   ops_out_meta_t out_meta_o;
`ifdef PPU_QUIRE_OVF_EN
   logic          ovf;
`endif

   int n_pass  = 0;
   int n_total = 0;

   fir_t one_f, one5_f, two_f, neg1_f, neg15_f, nar_f, tiny_f, huge_f;

   ppu_quire_acc dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .in_a_i         (in_a_i),
      .in_b_i         (in_b_i),
      .in_a_special_i (in_a_special_i),
      .in_b_special_i (in_b_special_i),
      .in_last_i      (in_last_i),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .out_meta_o     (out_meta_o),
      .out_nar_o      (out_nar_o),
      .out_zero_o     (out_zero_o)
`ifdef PPU_QUIRE_OVF_EN
      ,
      .ovf_o          (ovf)
`endif
   );

   always #5 clk_i = ~clk_i;

   function automatic fir_t mk(input logic s, input int te, input logic [MS-1:0] m);
      fir_t f;
      f.sign = s;
      f.te   = TE_BITS'(te);
      f.mant = m;
      return f;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send(input fir_t a, input fir_t b, input logic asp, input logic bsp, input logic last);
      in_valid_i     = 1'b1;
      in_a_i         = a;
      in_b_i         = b;
      in_a_special_i = asp;
      in_b_special_i = bsp;
      in_last_i      = last;
      step();
      in_valid_i     = 1'b0;
      in_last_i      = 1'b0;
      in_a_special_i = 1'b0;
      in_b_special_i = 1'b0;
   endtask

   // Called one cycle after the last beat was accepted; expects two more cycles.
   task automatic wait_out(input string tag);
      int n = 0;
      while (!out_valid_o && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'd2);
   endtask

   task automatic chk_meta(input string tag, input logic s, input logic [6:0] te,
                           input logic [39:0] frac, input logic tr, input logic z, input logic nar);
      $display("txn %s: sign=%0d te=%0d frac=%h trunc=%0d zero=%0d nar=%0d", tag,
               out_meta_o.sign, out_meta_o.te, out_meta_o.frac, out_meta_o.frac_truncated,
               out_zero_o, out_nar_o);
      chk({tag, "_sign"},  64'(out_meta_o.sign), 64'(s));
      chk({tag, "_te"},    64'($unsigned(out_meta_o.te)), 64'(te));
      chk({tag, "_frac"},  64'(out_meta_o.frac), 64'(frac));
      chk({tag, "_trunc"}, 64'(out_meta_o.frac_truncated), 64'(tr));
      chk({tag, "_zero"},  64'(out_zero_o), 64'(z));
      chk({tag, "_nar"},   64'(out_nar_o), 64'(nar));
   endtask

   task automatic take(input string tag);
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      chk({tag, "_valid_cleared"}, 64'(out_valid_o), 64'd0);
      chk({tag, "_ready_back"},    64'(in_ready_o), 64'd1);
   endtask

   initial begin
      logic seen_valid;
      one_f   = mk(1'b0, 0,   14'h2000);
      one5_f  = mk(1'b0, 0,   14'h3000);
      two_f   = mk(1'b0, 1,   14'h2000);
      neg1_f  = mk(1'b1, 0,   14'h2000);
      neg15_f = mk(1'b1, 0,   14'h3000);
      nar_f   = mk(1'b1, 0,   14'h0000);
      tiny_f  = mk(1'b0, -64, 14'h2000);
      huge_f  = mk(1'b0, 63,  14'h2000);
      in_valid_i = 1'b0; in_last_i = 1'b0; out_ready_i = 1'b0;
      in_a_special_i = 1'b0; in_b_special_i = 1'b0;
      in_a_i = '0; in_b_i = '0;

      #2;
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_in_ready",  64'(in_ready_o),  64'd1);
      chk("rst_meta",      64'(out_meta_o),  64'd0);
      chk("rst_nar",       64'(out_nar_o),   64'd0);
      chk("rst_zero",      64'(out_zero_o),  64'd0);
      step(); step();
      rst_i = 1'b0;

      // 1.0 x 1.0 with exact latency check
      send(one_f, one_f, 1'b0, 1'b0, 1'b1);
      chk("t1_ready_drain", 64'(in_ready_o), 64'd0);
      chk("t1_valid_t1", 64'(out_valid_o), 64'd0);
      step();
      chk("t1_valid_t2", 64'(out_valid_o), 64'd0);
      step();
      chk("t1_valid_t3", 64'(out_valid_o), 64'd1);
      chk_meta("t1", 1'b0, 7'h00, 40'h0, 1'b0, 1'b0, 1'b0);
      take("t1");

      // 1.5 x 2.0 = 3.0
      send(one5_f, two_f, 1'b0, 1'b0, 1'b1);
      wait_out("t2");
      chk_meta("t2", 1'b0, 7'h01, 40'h80_0000_0000, 1'b0, 1'b0, 1'b0);
      take("t2");

      // 1 + 1 - 1, then hold output against back-pressure
      send(one_f, one_f, 1'b0, 1'b0, 1'b0);
      send(one_f, one_f, 1'b0, 1'b0, 1'b0);
      send(neg1_f, one_f, 1'b0, 1'b0, 1'b1);
      wait_out("t3");
      chk_meta("t3", 1'b0, 7'h00, 40'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_hold_valid", 64'(out_valid_o), 64'd1);
         chk("t3_hold_ready", 64'(in_ready_o),  64'd0);
         chk("t3_hold_meta",  64'(out_meta_o),  64'd0);
         chk("t3_hold_zero",  64'(out_zero_o),  64'd0);
      end
      take("t3");

      // Exact cancellation, then a fresh dot product on a cleared quire
      send(one5_f, one_f, 1'b0, 1'b0, 1'b0);
      send(neg15_f, one_f, 1'b0, 1'b0, 1'b1);
      wait_out("t4");
      chk_meta("t4", 1'b0, 7'h00, 40'h0, 1'b0, 1'b1, 1'b0);
      chk("t4_meta_all_zero", 64'(out_meta_o), 64'd0);
      take("t4");
      send(one_f, one_f, 1'b0, 1'b0, 1'b1);
      wait_out("t4b");
      chk_meta("t4b", 1'b0, 7'h00, 40'h0, 1'b0, 1'b0, 1'b0);
      take("t4b");

      // NaR mid-stream, then a clean dot product
      send(one_f, one_f, 1'b0, 1'b0, 1'b0);
      send(nar_f, one_f, 1'b1, 1'b0, 1'b0);
      send(one_f, one_f, 1'b0, 1'b0, 1'b1);
      wait_out("t5");
      chk_meta("t5", 1'b0, 7'h00, 40'h0, 1'b0, 1'b0, 1'b1);
      chk("t5_meta_all_zero", 64'(out_meta_o), 64'd0);
      take("t5");
      send(two_f, one_f, 1'b0, 1'b0, 1'b1);
      wait_out("t5b");
      chk_meta("t5b", 1'b0, 7'h01, 40'h0, 1'b0, 1'b0, 1'b0);
      take("t5b");

      // Exponent clamping at both ends of the TE range
      send(tiny_f, tiny_f, 1'b0, 1'b0, 1'b1);
      wait_out("t6lo");
      chk_meta("t6lo", 1'b0, 7'h40, 40'h0, 1'b1, 1'b0, 1'b0);
      take("t6lo");
      send(huge_f, huge_f, 1'b0, 1'b0, 1'b1);
      wait_out("t6hi");
      chk_meta("t6hi", 1'b0, 7'h3F, 40'h0, 1'b1, 1'b0, 1'b0);
      take("t6hi");

      // Reset while two beats are in flight
      send(one_f, one_f, 1'b0, 1'b0, 1'b0);
      send(one_f, one_f, 1'b0, 1'b0, 1'b1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid_o) seen_valid = 1'b1;
         step();
      end
      chk("t7_no_output", 64'(seen_valid), 64'd0);
      chk("t7_ready", 64'(in_ready_o), 64'd1);
      send(one_f, one_f, 1'b0, 1'b0, 1'b1);
      wait_out("t7");
      chk_meta("t7", 1'b0, 7'h00, 40'h0, 1'b0, 1'b0, 1'b0);
      take("t7");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
